rtc_bus_arbiter: RTL and testbench

Sequencing arbiter that shares the single RTC protocol engine among the four register-access machines: initialization, time/date write, chronometer write and background read. It replaces the static combinational address/data/indicator multiplexing with a registered request/grant handshake, so exactly one machine owns the RTC bus per transaction. It sits between the access machines and the protocol/function-generator pair, and drives the read/write indicator those blocks consume.

---
 rtl/rtc_arb_pkg.sv | 39 +++
 rtl/rtc_prio_picker.sv | 25 ++
 rtl/rtc_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_arb_pkg.sv
// rtl/rtc_arb_pkg.sv - shared constants, state encoding and field helpers for the RTC bus arbiter
package rtc_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int RTC_AW  = 8;
   localparam int RTC_DW  = 8;

   localparam int IDX_INIT  = 0;
   localparam int IDX_WRITE = 1;
   localparam int IDX_CRONO = 2;
   localparam int IDX_READ  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // Pull the byte lane of the one-hot selected requester out of a packed bus.
   function automatic logic [RTC_DW-1:0] sel_byte(input logic [NUM_REQ*RTC_DW-1:0] bus,
                                                  input logic [NUM_REQ-1:0]        onehot);
      logic [RTC_DW-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (onehot[i]) begin
            r = r | bus[RTC_DW*i +: RTC_DW];
         end
      end
      return r;
   endfunction

   // Pull the flag of the one-hot selected requester out of a per-requester vector.
   function automatic logic sel_bit(input logic [NUM_REQ-1:0] v,
                                    input logic [NUM_REQ-1:0] onehot);
      return |(v & onehot);
   endfunction

endpackage

// File: rtl/rtc_prio_picker.sv
// rtl/rtc_prio_picker.sv - fixed-priority winner select with read starvation override
module rtc_prio_picker (
   input  logic [3:0] req,
   input  logic       starve_hit,
   output logic [3:0] winner
);
   import rtc_arb_pkg::*;

   // init > write > crono > read, unless the read requester has waited too long
   always_comb begin
      winner = 4'b0000;
      if (starve_hit && req[IDX_READ]) begin
         winner[IDX_READ] = 1'b1;
      end else if (req[IDX_INIT]) begin
         winner[IDX_INIT] = 1'b1;
      end else if (req[IDX_WRITE]) begin
         winner[IDX_WRITE] = 1'b1;
      end else if (req[IDX_CRONO]) begin
         winner[IDX_CRONO] = 1'b1;
      end else if (req[IDX_READ]) begin
         winner[IDX_READ] = 1'b1;
      end
   end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - request/grant sequencer sharing one RTC protocol engine among four access machines
module rtc_bus_arbiter #(
   parameter int STARVE_MAX  = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [3:0]  lock,
   input  logic [3:0]  we,
   input  logic [31:0] addr_bus,
   input  logic [31:0] wdata_bus,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic [7:0]  rdata,
   output logic        timeout,
   output logic        rtc_start,
   output logic        rtc_we,
   output logic [7:0]  rtc_addr,
   output logic [7:0]  rtc_wdata,
   input  logic        rtc_done,
   input  logic [7:0]  rtc_rdata,
   output logic        ind_maquina
);
   import rtc_arb_pkg::*;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
   localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT_CYC);

   arb_state_e        state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [3:0]        done_q, done_d;
   logic [RTC_DW-1:0] rdata_q, rdata_d;
   logic              timeout_q, timeout_d;
   logic              rtc_start_q, rtc_start_d;
   logic              rtc_we_q, rtc_we_d;
   logic [RTC_AW-1:0] rtc_addr_q, rtc_addr_d;
   logic [RTC_DW-1:0] rtc_wdata_q, rtc_wdata_d;
   logic [7:0]        starve_cnt_q, starve_cnt_d;
   logic [7:0]        tmo_cnt_q, tmo_cnt_d;

   logic [3:0]        winner;
   logic              starve_hit;
   logic [7:0]        tmo_next;
   logic              burst_go;

   assign starve_hit = req[IDX_READ] && (starve_cnt_q == STARVE_LIM);
   assign tmo_next   = tmo_cnt_q + 8'd1;
   // the current owner holds lock and is still asking: stay on the bus
   assign burst_go   = |(lock & req & gnt_q);

   rtc_prio_picker u_picker (
      .req        (req),
      .starve_hit (starve_hit),
      .winner     (winner)
   );

   // next-state, grant capture, completion and counter updates
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      done_d       = 4'b0000;
      rdata_d      = rdata_q;
      timeout_d    = 1'b0;
      rtc_start_d  = 1'b0;
      rtc_we_d     = rtc_we_q;
      rtc_addr_d   = rtc_addr_q;
      rtc_wdata_d  = rtc_wdata_q;
      starve_cnt_d = starve_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;

      if (!req[IDX_READ]) begin
         starve_cnt_d = 8'd0;
      end

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d       = winner;
               rtc_we_d    = sel_bit(we, winner);
               rtc_addr_d  = sel_byte(addr_bus, winner);
               rtc_wdata_d = sel_byte(wdata_bus, winner);
               rtc_start_d = 1'b1;
               state_d     = ST_ISSUE;
               if (winner[IDX_READ]) begin
                  starve_cnt_d = 8'd0;
               end else if (req[IDX_READ] && (starve_cnt_q != STARVE_LIM)) begin
                  starve_cnt_d = starve_cnt_q + 8'd1;
               end
            end
         end

         ST_ISSUE: begin
            tmo_cnt_d = 8'd0;
            state_d   = ST_WAIT;
         end

         ST_WAIT: begin
            if (rtc_done) begin
               if (!rtc_we_q) begin
                  rdata_d = rtc_rdata;
               end
               done_d    = gnt_q;
               tmo_cnt_d = 8'd0;
               state_d   = ST_DONE;
            end else if (tmo_next == TMO_LIM) begin
               timeout_d = 1'b1;
               done_d    = gnt_q;
               rdata_d   = '0;
               tmo_cnt_d = 8'd0;
               state_d   = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_next;
            end
         end

         ST_DONE: begin
            if (burst_go) begin
               rtc_we_d    = sel_bit(we, gnt_q);
               rtc_addr_d  = sel_byte(addr_bus, gnt_q);
               rtc_wdata_d = sel_byte(wdata_bus, gnt_q);
               rtc_start_d = 1'b1;
               state_d     = ST_ISSUE;
            end else begin
               gnt_d   = 4'b0000;
               state_d = ST_IDLE;
            end
         end

         default: begin
            gnt_d   = 4'b0000;
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         gnt_q        <= 4'b0000;
         done_q       <= 4'b0000;
         rdata_q      <= '0;
         timeout_q    <= 1'b0;
         rtc_start_q  <= 1'b0;
         rtc_we_q     <= 1'b0;
         rtc_addr_q   <= '0;
         rtc_wdata_q  <= '0;
         starve_cnt_q <= 8'd0;
         tmo_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         rdata_q      <= rdata_d;
         timeout_q    <= timeout_d;
         rtc_start_q  <= rtc_start_d;
         rtc_we_q     <= rtc_we_d;
         rtc_addr_q   <= rtc_addr_d;
         rtc_wdata_q  <= rtc_wdata_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign rdata       = rdata_q;
   assign timeout     = timeout_q;
   assign rtc_start   = rtc_start_q;
   assign rtc_we      = rtc_we_q;
   assign rtc_addr    = rtc_addr_q;
   assign rtc_wdata   = rtc_wdata_q;
   // write-type owners drive the indicator low; idle and read ownership leave it high
   assign ind_maquina = (state_q == ST_IDLE) || gnt_q[IDX_READ];

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - scoreboard bench for rtc_bus_arbiter with a behavioural RTC engine
module tb_rtc_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, lock, we;
   logic [31:0] addr_bus, wdata_bus;
   logic [3:0]  gnt, done;
   logic [7:0]  rdata;
   logic        timeout, rtc_start, rtc_we;
   logic [7:0]  rtc_addr, rtc_wdata;
   logic        rtc_done;
   logic [7:0]  rtc_rdata;
   logic        ind_maquina;

   always #5 clk = ~clk;

   rtc_bus_arbiter #(.STARVE_MAX(2), .TIMEOUT_CYC(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .lock        (lock),
      .we          (we),
      .addr_bus    (addr_bus),
      .wdata_bus   (wdata_bus),
      .gnt         (gnt),
      .done        (done),
      .rdata       (rdata),
      .timeout     (timeout),
      .rtc_start   (rtc_start),
      .rtc_we      (rtc_we),
      .rtc_addr    (rtc_addr),
      .rtc_wdata   (rtc_wdata),
      .rtc_done    (rtc_done),
      .rtc_rdata   (rtc_rdata),
      .ind_maquina (ind_maquina)
   );

   typedef struct packed {
      logic [3:0] g;
      logic       is_we;
      logic [7:0] a;
      logic [7:0] wd;
      logic       ind;
   } issue_t;

   typedef struct packed {
      logic [3:0] d;
      logic [7:0] rd;
      logic       tmo;
   } resp_t;

   issue_t iss_q[$];
   resp_t  rsp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     last_start_cyc = 0;
   int     eng_lat = 5;
   logic   eng_silent = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_issue(input logic [3:0] g, input logic w, input logic [7:0] a,
                            input logic [7:0] wd, input logic ind);
      issue_t e;
      e.g = g; e.is_we = w; e.a = a; e.wd = wd; e.ind = ind;
      iss_q.push_back(e);
   endtask

   task automatic exp_resp(input logic [3:0] d, input logic [7:0] rd, input logic tmo);
      resp_t e;
      e.d = d; e.rd = rd; e.tmo = tmo;
      rsp_q.push_back(e);
   endtask

   task automatic wait_done(output logic [3:0] d);
      d = 4'b0000;
      for (int k = 0; k < 60 && d == 4'b0000; k++) begin
         @(negedge clk);
         if ((|done) === 1'b1) d = done;
      end
      if (d == 4'b0000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_done: no done pulse within 60 cycles, required one");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"}, gnt, 4'b0000);
      chk({tag, "_done"}, done, 4'b0000);
      chk({tag, "_rdata"}, rdata, 8'h00);
      chk({tag, "_timeout"}, timeout, 1'b0);
      chk({tag, "_rtc_start"}, rtc_start, 1'b0);
      chk({tag, "_rtc_we"}, rtc_we, 1'b0);
      chk({tag, "_rtc_addr"}, rtc_addr, 8'h00);
      chk({tag, "_rtc_wdata"}, rtc_wdata, 8'h00);
      chk({tag, "_ind"}, ind_maquina, 1'b1);
   endtask

   // engine model: answers each start after eng_lat cycles with addr ^ 8'h64
   initial begin
      int         pend;
      logic [7:0] pa;
      pend = 0;
      pa = 8'h00;
      rtc_done = 1'b0;
      rtc_rdata = 8'h00;
      forever begin
         @(negedge clk);
         rtc_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               rtc_done = 1'b1;
               rtc_rdata = pa ^ 8'h64;
            end
         end
         if (rtc_start === 1'b1 && !eng_silent) begin
            pend = eng_lat;
            pa = rtc_addr;
         end
      end
   end

   // issue monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rtc_start === 1'b1) begin
            last_start_cyc = cyc;
            if (iss_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_start: got start gnt=%b addr=%h, required none", gnt, rtc_addr);
            end else begin
               issue_t e;
               e = iss_q.pop_front();
               chk("issue_gnt", gnt, e.g);
               chk("issue_we", rtc_we, e.is_we);
               chk("issue_addr", rtc_addr, e.a);
               chk("issue_wdata", rtc_wdata, e.wd);
               chk("issue_ind", ind_maquina, e.ind);
            end
         end
      end
   end

   // response monitor
   initial begin
      forever begin
         @(negedge clk);
         if ((|done) === 1'b1 || timeout === 1'b1) begin
            if (rsp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=%b timeout=%b, required none", done, timeout);
            end else begin
               resp_t e;
               e = rsp_q.pop_front();
               chk("resp_done", done, e.d);
               chk("resp_rdata", rdata, e.rd);
               chk("resp_timeout", timeout, e.tmo);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] d;
      logic       seen;
      reset = 1'b1;
      req = 4'b0000;
      lock = 4'b0000;
      we = 4'b0000;
      addr_bus = 32'h0;
      wdata_bus = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // single read requester
      addr_bus = 32'h21_00_00_00;
      exp_issue(4'b1000, 1'b0, 8'h21, 8'h00, 1'b1);
      exp_resp(4'b1000, 8'h45, 1'b0);
      req = 4'b1000;
      @(posedge clk);
      #1;
      chk("t1_gnt_next_cycle", gnt, 4'b1000);
      chk("t1_start_next_cycle", rtc_start, 1'b1);
      chk("t1_ind", ind_maquina, 1'b1);
      wait_done(d);
      req = 4'b0000;
      chk("t1_done_bit", d, 4'b1000);
      repeat (3) @(negedge clk);

      // all four at once; with STARVE_MAX=2 the read overtakes crono
      we = 4'b0111;
      addr_bus = {8'h13, 8'h12, 8'h11, 8'h10};
      wdata_bus = {8'h00, 8'hA2, 8'hA1, 8'hA0};
      exp_issue(4'b0001, 1'b1, 8'h10, 8'hA0, 1'b0);
      exp_issue(4'b0010, 1'b1, 8'h11, 8'hA1, 1'b0);
      exp_issue(4'b1000, 1'b0, 8'h13, 8'h00, 1'b1);
      exp_issue(4'b0100, 1'b1, 8'h12, 8'hA2, 1'b0);
      exp_resp(4'b0001, 8'h45, 1'b0);
      exp_resp(4'b0010, 8'h45, 1'b0);
      exp_resp(4'b1000, 8'h77, 1'b0);
      exp_resp(4'b0100, 8'h77, 1'b0);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_done(d);
         req = req & ~d;
      end
      chk("t2_req_drained", req, 4'b0000);
      repeat (3) @(negedge clk);

      // write and crono keep requesting, read held: read wins after 2 write grants
      we = 4'b0110;
      addr_bus = {8'h33, 8'h32, 8'h31, 8'h30};
      wdata_bus = {8'h00, 8'hB2, 8'hB1, 8'hB0};
      exp_issue(4'b0010, 1'b1, 8'h31, 8'hB1, 1'b0);
      exp_issue(4'b0010, 1'b1, 8'h31, 8'hB1, 1'b0);
      exp_issue(4'b1000, 1'b0, 8'h33, 8'h00, 1'b1);
      exp_resp(4'b0010, 8'h77, 1'b0);
      exp_resp(4'b0010, 8'h77, 1'b0);
      exp_resp(4'b1000, 8'h57, 1'b0);
      req = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         wait_done(d);
      end
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // locked init burst of four, write waiting throughout
      we = 4'b0011;
      addr_bus = {8'h00, 8'h00, 8'h41, 8'h00};
      wdata_bus = {8'h00, 8'h00, 8'hD1, 8'hC0};
      for (int k = 0; k < 4; k++) begin
         exp_issue(4'b0001, 1'b1, 8'(k), 8'(8'hC0 + k), 1'b0);
         exp_resp(4'b0001, 8'h57, 1'b0);
      end
      exp_issue(4'b0010, 1'b1, 8'h41, 8'hD1, 1'b0);
      exp_resp(4'b0010, 8'h57, 1'b0);
      lock = 4'b0001;
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         wait_done(d);
         if (k < 3) begin
            addr_bus[7:0] = 8'(k + 1);
            wdata_bus[7:0] = 8'(8'hC0 + k + 1);
            @(negedge clk);
            chk("t4_gnt_held", gnt, 4'b0001);
         end else begin
            lock = 4'b0000;
            req[0] = 1'b0;
         end
      end
      wait_done(d);
      req = 4'b0000;
      chk("t4_write_after_burst", d, 4'b0010);
      repeat (3) @(negedge clk);

      // silent engine: write aborts after TIMEOUT_CYC cycles in WAIT
      eng_silent = 1'b1;
      we = 4'b0010;
      addr_bus = {8'h00, 8'h00, 8'h50, 8'h00};
      wdata_bus = {8'h00, 8'h00, 8'hE5, 8'h00};
      exp_issue(4'b0010, 1'b1, 8'h50, 8'hE5, 1'b0);
      exp_resp(4'b0010, 8'h00, 1'b1);
      req = 4'b0010;
      wait_done(d);
      req = 4'b0000;
      chk("t5_timeout_latency", cyc - last_start_cyc, 32'd11);
      @(negedge clk);
      chk("t5_gnt_released", gnt, 4'b0000);
      chk("t5_ind_idle", ind_maquina, 1'b1);
      eng_silent = 1'b0;
      repeat (2) @(negedge clk);

      // reset during WAIT: no done, late rtc_done ignored
      eng_lat = 8;
      we = 4'b0000;
      addr_bus = {8'h00, 8'h00, 8'h00, 8'h60};
      wdata_bus = 32'h0;
      exp_issue(4'b0001, 1'b0, 8'h60, 8'h00, 1'b0);
      req = 4'b0001;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (rtc_start === 1'b1) seen = 1'b1;
      end
      chk("t6_start_seen", seen, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req = 4'b0000;
      @(posedge clk);
      #1;
      check_reset_outputs("t6");
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("t6_gnt_idle", gnt, 4'b0000);
      chk("t6_rdata_after", rdata, 8'h00);

      chk("issue_queue_empty", iss_q.size(), 32'd0);
      chk("resp_queue_empty", rsp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
